// File: rtl/axil_window_bridge_pkg.sv
// Shared constants, state encodings and helpers for the AXI4-Lite window bridge.
package axil_window_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int MAX_WIN = 8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_ERR  = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2,
    W_ERR  = 2'd3
  } wr_state_e;

  // Mask keeping the address bits above a window's size, i.e. the bits compared on decode.
  function automatic logic [31:0] win_mask(input logic [4:0] bits);
    return 32'hFFFF_FFFF << bits;
  endfunction

endpackage

// File: rtl/axil_window_bridge_if.sv
// AXI4-Lite channel bundle. "master" is the side issuing requests, "slave" the side answering.
interface axil_window_bridge_if;

  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/axil_window_decode.sv
// Combinational window decoder: address -> hit, matching window index, rebased/scaled address.
module axil_window_decode
  import axil_window_bridge_pkg::*;
#(
  parameter int                 NWIN      = 4,
  parameter logic [NWIN*32-1:0] WIN_BASE  = '0,
  parameter logic [NWIN*5-1:0]  WIN_BITS  = '0,
  parameter logic [NWIN*5-1:0]  WIN_SHIFT = '0
) (
  input  logic [31:0] addr,
  output logic        hit,
  output logic [2:0]  idx,
  output logic [31:0] xaddr
);

  // Scan from the top index down so the lowest matching window is the one left standing.
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    xaddr = '0;
    for (int i = NWIN - 1; i >= 0; i--) begin
      if ((addr & win_mask(WIN_BITS[5*i +: 5])) ==
          (WIN_BASE[32*i +: 32] & win_mask(WIN_BITS[5*i +: 5]))) begin
        hit   = 1'b1;
        idx   = 3'(i);
        xaddr = (addr - WIN_BASE[32*i +: 32]) << WIN_SHIFT[5*i +: 5];
      end
    end
  end

endmodule

// File: rtl/axil_window_bridge.sv
// Registered AXI4-Lite address-translation bridge with independent read and write FSMs.
//
// Read FSM
//   state  | meaning
//   R_IDLE | accepting AR; decode registered at acceptance
//   R_ADDR | presenting translated AR downstream until m_arready
//   R_DATA | R channel passed straight through until upstream handshake
//   R_ERR  | local DECERR response, rdata 0
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W in any order; each ready drops after its own capture
//   W_REQ  | presenting AW and W downstream; each valid drops after its own handshake
//   W_RESP | B channel passed straight through until upstream handshake
//   W_ERR  | local DECERR response, captured data dropped
module axil_window_bridge
  import axil_window_bridge_pkg::*;
#(
  parameter int                 NWIN      = 4,
  parameter logic [NWIN*32-1:0] WIN_BASE  = '0,
  parameter logic [NWIN*5-1:0]  WIN_BITS  = '0,
  parameter logic [NWIN*5-1:0]  WIN_SHIFT = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  axil_window_bridge_if.slave   s_axi,
  axil_window_bridge_if.master  m_axi,
  output logic                  err_hit
);

  // live_q holds every upstream ready low for the first cycle after reset.
  logic        live_q, live_d;

  rd_state_e   r_state_q, r_state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [2:0]  rd_prot_q, rd_prot_d;

  wr_state_e   w_state_q, w_state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic        wr_hit_q, wr_hit_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [2:0]  wr_prot_q, wr_prot_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        maw_done_q, maw_done_d;
  logic        mw_done_q, mw_done_d;

  logic        err_hit_q, err_hit_d;

  logic        ar_hit, aw_hit;
  logic [31:0] ar_xaddr, aw_xaddr;

  logic        s_arready_c, s_rvalid_c, m_arvalid_c, m_rready_c;
  logic [31:0] s_rdata_c;
  logic [1:0]  s_rresp_c;
  logic        s_awready_c, s_wready_c, s_bvalid_c;
  logic        m_awvalid_c, m_wvalid_c, m_bready_c;
  logic [1:0]  s_bresp_c;
  logic        aw_hs, w_hs, maw_fire, mw_fire;

  axil_window_decode #(
    .NWIN(NWIN), .WIN_BASE(WIN_BASE), .WIN_BITS(WIN_BITS), .WIN_SHIFT(WIN_SHIFT)
  ) u_ar_dec (
    .addr  (s_axi.araddr),
    .hit   (ar_hit),
    .idx   (),
    .xaddr (ar_xaddr)
  );

  axil_window_decode #(
    .NWIN(NWIN), .WIN_BASE(WIN_BASE), .WIN_BITS(WIN_BITS), .WIN_SHIFT(WIN_SHIFT)
  ) u_aw_dec (
    .addr  (s_axi.awaddr),
    .hit   (aw_hit),
    .idx   (),
    .xaddr (aw_xaddr)
  );

  // Read path next-state and channel outputs.
  always_comb begin
    r_state_d   = r_state_q;
    rd_addr_d   = rd_addr_q;
    rd_prot_d   = rd_prot_q;
    s_arready_c = 1'b0;
    s_rvalid_c  = 1'b0;
    s_rdata_c   = '0;
    s_rresp_c   = RESP_OKAY;
    m_arvalid_c = 1'b0;
    m_rready_c  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_arready_c = live_q;
        if (live_q && s_axi.arvalid) begin
          rd_prot_d = s_axi.arprot;
          if (ar_hit) begin
            rd_addr_d = ar_xaddr;
            r_state_d = R_ADDR;
          end else begin
            r_state_d = R_ERR;
          end
        end
      end
      R_ADDR: begin
        m_arvalid_c = 1'b1;
        if (m_axi.arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        m_rready_c = s_axi.rready;
        s_rvalid_c = m_axi.rvalid;
        s_rdata_c  = m_axi.rdata;
        s_rresp_c  = m_axi.rresp;
        if (m_axi.rvalid && s_axi.rready) r_state_d = R_IDLE;
      end
      R_ERR: begin
        s_rvalid_c = 1'b1;
        s_rresp_c  = RESP_DECERR;
        if (s_axi.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write path next-state and channel outputs.
  always_comb begin
    w_state_d   = w_state_q;
    aw_got_d    = aw_got_q;
    w_got_d     = w_got_q;
    wr_hit_d    = wr_hit_q;
    wr_addr_d   = wr_addr_q;
    wr_prot_d   = wr_prot_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    maw_done_d  = maw_done_q;
    mw_done_d   = mw_done_q;
    s_awready_c = 1'b0;
    s_wready_c  = 1'b0;
    s_bvalid_c  = 1'b0;
    s_bresp_c   = RESP_OKAY;
    m_awvalid_c = 1'b0;
    m_wvalid_c  = 1'b0;
    m_bready_c  = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    maw_fire    = 1'b0;
    mw_fire     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_awready_c = live_q && !aw_got_q;
        s_wready_c  = live_q && !w_got_q;
        aw_hs       = s_awready_c && s_axi.awvalid;
        w_hs        = s_wready_c && s_axi.wvalid;
        if (aw_hs) begin
          aw_got_d  = 1'b1;
          wr_hit_d  = aw_hit;
          wr_addr_d = aw_xaddr;
          wr_prot_d = s_axi.awprot;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axi.wdata;
          wstrb_d = s_axi.wstrb;
        end
        // Leave as soon as the second half lands; the hit flag may be arriving this very cycle.
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = (aw_hs ? aw_hit : wr_hit_q) ? W_REQ : W_ERR;
        end
      end
      W_REQ: begin
        m_awvalid_c = !maw_done_q;
        m_wvalid_c  = !mw_done_q;
        maw_fire    = m_awvalid_c && m_axi.awready;
        mw_fire     = m_wvalid_c && m_axi.wready;
        if (maw_fire) maw_done_d = 1'b1;
        if (mw_fire)  mw_done_d  = 1'b1;
        if ((maw_done_q || maw_fire) && (mw_done_q || mw_fire)) begin
          maw_done_d = 1'b0;
          mw_done_d  = 1'b0;
          w_state_d  = W_RESP;
        end
      end
      W_RESP: begin
        m_bready_c = s_axi.bready;
        s_bvalid_c = m_axi.bvalid;
        s_bresp_c  = m_axi.bresp;
        if (m_axi.bvalid && s_axi.bready) w_state_d = W_IDLE;
      end
      W_ERR: begin
        s_bvalid_c = 1'b1;
        s_bresp_c  = RESP_DECERR;
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Flag locally generated DECERR responses the cycle after they are taken upstream.
  always_comb begin
    live_d    = 1'b1;
    err_hit_d = ((r_state_q == R_ERR) && s_axi.rready) ||
                ((w_state_q == W_ERR) && s_axi.bready);
  end

  // State and capture registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q     <= 1'b0;
      r_state_q  <= R_IDLE;
      rd_addr_q  <= '0;
      rd_prot_q  <= '0;
      w_state_q  <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      wr_hit_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_prot_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      maw_done_q <= 1'b0;
      mw_done_q  <= 1'b0;
      err_hit_q  <= 1'b0;
    end else begin
      live_q     <= live_d;
      r_state_q  <= r_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_prot_q  <= rd_prot_d;
      w_state_q  <= w_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      wr_hit_q   <= wr_hit_d;
      wr_addr_q  <= wr_addr_d;
      wr_prot_q  <= wr_prot_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      maw_done_q <= maw_done_d;
      mw_done_q  <= mw_done_d;
      err_hit_q  <= err_hit_d;
    end
  end

  assign s_axi.arready = s_arready_c;
  assign s_axi.rvalid  = s_rvalid_c;
  assign s_axi.rdata   = s_rdata_c;
  assign s_axi.rresp   = s_rresp_c;
  assign s_axi.awready = s_awready_c;
  assign s_axi.wready  = s_wready_c;
  assign s_axi.bvalid  = s_bvalid_c;
  assign s_axi.bresp   = s_bresp_c;

  assign m_axi.araddr  = rd_addr_q;
  assign m_axi.arprot  = rd_prot_q;
  assign m_axi.arvalid = m_arvalid_c;
  assign m_axi.rready  = m_rready_c;
  assign m_axi.awaddr  = wr_addr_q;
  assign m_axi.awprot  = wr_prot_q;
  assign m_axi.awvalid = m_awvalid_c;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = m_wvalid_c;
  assign m_axi.bready  = m_bready_c;

  assign err_hit = err_hit_q;

endmodule

// File: tb/tb_axil_window_bridge.sv
// Scoreboard bench for axil_window_bridge: directed transactions push expectations,
// channel monitors pop and compare on every handshake.
`timescale 1ns/1ps
module tb_axil_window_bridge;

  localparam int                 NWIN      = 2;
  localparam logic [NWIN*32-1:0] WIN_BASE  = {32'h1000_0000, 32'h8000_0000};
  localparam logic [NWIN*5-1:0]  WIN_BITS  = {5'd8, 5'd12};
  localparam logic [NWIN*5-1:0]  WIN_SHIFT = {5'd2, 5'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_hit;

  always #5 clk = ~clk;

  axil_window_bridge_if s_if ();
  axil_window_bridge_if m_if ();

  axil_window_bridge #(
    .NWIN(NWIN), .WIN_BASE(WIN_BASE), .WIN_BITS(WIN_BITS), .WIN_SHIFT(WIN_SHIFT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_axi   (s_if),
    .m_axi   (m_if),
    .err_hit (err_hit)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int exp_err = 0;
  int ar_lat = 0, aw_lat = 0, w_lat = 0;

  logic [34:0] exp_ar[$];
  logic [34:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [33:0] exp_r[$];
  logic [1:0]  exp_b[$];
  logic [33:0] rd_ret[$];
  logic [1:0]  b_ret[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=handshake required=none (t=%0t)", nm, $time);
  endtask

  always @(posedge clk) cyc++;

  // ---------------- monitors (sample mid-cycle) ----------------
  always @(negedge clk) begin : mon_ar
    logic [34:0] e;
    if (!rst && m_if.arvalid && m_if.arready) begin
      if (exp_ar.size() == 0) unexpected("m_ar_extra");
      else begin
        e = exp_ar.pop_front();
        check("m_araddr", m_if.araddr, e[34:3]);
        check("m_arprot", m_if.arprot, e[2:0]);
      end
    end
  end

  int   s_ar_cyc = 0;
  logic m_arv_prev = 1'b0;
  always @(negedge clk) begin : mon_ar_lat
    if (s_if.arvalid && s_if.arready) s_ar_cyc = cyc;
    if (!rst && m_if.arvalid && !m_arv_prev) check("ar_latency", 64'(cyc - s_ar_cyc), 64'd1);
    m_arv_prev = m_if.arvalid;
  end

  always @(negedge clk) begin : mon_aw
    logic [34:0] e;
    if (!rst && m_if.awvalid && m_if.awready) begin
      if (exp_aw.size() == 0) unexpected("m_aw_extra");
      else begin
        e = exp_aw.pop_front();
        check("m_awaddr", m_if.awaddr, e[34:3]);
        check("m_awprot", m_if.awprot, e[2:0]);
      end
    end
  end

  always @(negedge clk) begin : mon_w
    logic [35:0] e;
    if (!rst && m_if.wvalid && m_if.wready) begin
      if (exp_w.size() == 0) unexpected("m_w_extra");
      else begin
        e = exp_w.pop_front();
        check("m_wdata", m_if.wdata, e[35:4]);
        check("m_wstrb", m_if.wstrb, e[3:0]);
      end
    end
  end

  logic        r_stall_prev = 1'b0;
  logic [33:0] r_prev = '0;
  always @(negedge clk) begin : mon_r
    logic [33:0] e;
    if (rst) r_stall_prev = 1'b0;
    else begin
      if (r_stall_prev) begin
        check("s_rvalid_held", s_if.rvalid, 1'b1);
        check("s_rdata_held", {s_if.rdata, s_if.rresp}, r_prev);
      end
      r_stall_prev = s_if.rvalid && !s_if.rready;
      r_prev = {s_if.rdata, s_if.rresp};
      if (s_if.rvalid && s_if.rready) begin
        if (exp_r.size() == 0) unexpected("s_r_extra");
        else begin
          e = exp_r.pop_front();
          check("s_rdata", s_if.rdata, e[33:2]);
          check("s_rresp", s_if.rresp, e[1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    if (!rst && s_if.bvalid && s_if.bready) begin
      if (exp_b.size() == 0) unexpected("s_b_extra");
      else check("s_bresp", s_if.bresp, exp_b.pop_front());
    end
  end

  always @(negedge clk) if (!rst && err_hit) err_cnt++;

  // ---------------- downstream slave model ----------------
  logic rst_s, ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s, arv_s, awv_s, wv_s;
  always @(negedge clk) begin
    rst_s   = rst;
    ar_hs_s = m_if.arvalid && m_if.arready;
    r_hs_s  = m_if.rvalid && m_if.rready;
    aw_hs_s = m_if.awvalid && m_if.awready;
    w_hs_s  = m_if.wvalid && m_if.wready;
    b_hs_s  = m_if.bvalid && m_if.bready;
    arv_s   = m_if.arvalid;
    awv_s   = m_if.awvalid;
    wv_s    = m_if.wvalid;
  end

  initial begin : slave_model
    int ar_wait, aw_wait, w_wait;
    bit aw_seen, w_seen;
    ar_wait = 0; aw_wait = 0; w_wait = 0; aw_seen = 0; w_seen = 0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = '0;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_s) begin
        m_if.arready = 0; m_if.rvalid = 0; m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; aw_seen = 0; w_seen = 0;
        continue;
      end
      if (r_hs_s) m_if.rvalid = 0;
      if (ar_hs_s) begin
        m_if.arready = 0;
        ar_wait = 0;
        if (rd_ret.size() > 0) {m_if.rdata, m_if.rresp} = rd_ret.pop_front();
        else {m_if.rdata, m_if.rresp} = '0;
        m_if.rvalid = 1;
      end else if (arv_s && !m_if.arready) begin
        if (ar_wait >= ar_lat) m_if.arready = 1; else ar_wait++;
      end
      if (aw_hs_s) begin
        m_if.awready = 0; aw_seen = 1;
      end else if (awv_s && !m_if.awready && !aw_seen) begin
        if (aw_wait >= aw_lat) m_if.awready = 1; else aw_wait++;
      end
      if (w_hs_s) begin
        m_if.wready = 0; w_seen = 1;
      end else if (wv_s && !m_if.wready && !w_seen) begin
        if (w_wait >= w_lat) m_if.wready = 1; else w_wait++;
      end
      if (b_hs_s) m_if.bvalid = 0;
      if (aw_seen && w_seen && !m_if.bvalid) begin
        m_if.bresp = (b_ret.size() > 0) ? b_ret.pop_front() : 2'b00;
        m_if.bvalid = 1;
        aw_seen = 0; w_seen = 0; aw_wait = 0; w_wait = 0;
      end
    end
  end

  // ---------------- upstream drivers ----------------
  task automatic ar_send(input logic [31:0] a, input logic [2:0] p);
    bit ok = 0;
    s_if.araddr = a; s_if.arprot = p; s_if.arvalid = 1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_if.arready) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL ar_accept actual=no_ready required=ready"); end
    @(posedge clk); #1;
    s_if.arvalid = 0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [2:0] p);
    bit ok = 0;
    s_if.awaddr = a; s_if.awprot = p; s_if.awvalid = 1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_if.awready) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL aw_accept actual=no_ready required=ready"); end
    @(posedge clk); #1;
    s_if.awvalid = 0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    s_if.wdata = d; s_if.wstrb = s; s_if.wvalid = 1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_if.wready) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL w_accept actual=no_ready required=ready"); end
    @(posedge clk); #1;
    s_if.wvalid = 0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_ar.size() + exp_aw.size() + exp_w.size() + exp_r.size() + exp_b.size()) != 0
           && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain actual=pending required=empty", nm);
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = 0; s_if.rready = 1;
    s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = 0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = 0; s_if.bready = 1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", s_if.arready, 1'b0);
    check("rst_awready", s_if.awready, 1'b0);
    check("rst_wready", s_if.wready, 1'b0);
    check("rst_valids", {s_if.rvalid, s_if.bvalid, m_if.arvalid, m_if.awvalid, m_if.wvalid}, 5'b0);
    check("rst_m_readies", {m_if.rready, m_if.bready}, 2'b0);
    check("rst_err_hit", err_hit, 1'b0);
    check("rst_addrs", {m_if.araddr, m_if.awaddr}, 64'h0);
    check("rst_wdata", {m_if.wdata, m_if.wstrb}, 36'h0);
    check("rst_resp_data", {s_if.rdata, s_if.rresp, s_if.bresp}, 36'h0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_readies", {s_if.arready, s_if.awready, s_if.wready}, 3'b111);
    @(posedge clk); #1;

    // read hit, window 0
    exp_ar.push_back({32'h0000_0123, 3'b010});
    rd_ret.push_back({32'hDEAD_BEEF, 2'b00});
    exp_r.push_back({32'hDEAD_BEEF, 2'b00});
    ar_send(32'h8000_0123, 3'b010);
    wait_drain("rd_win0");

    // read hit, window 1 (shift 2); downstream SLVERR forwarded unchanged
    exp_ar.push_back({32'h0000_0040, 3'b000});
    rd_ret.push_back({32'h1234_5678, 2'b10});
    exp_r.push_back({32'h1234_5678, 2'b10});
    ar_send(32'h1000_0010, 3'b000);
    wait_drain("rd_win1");

    // write hit, window 1
    exp_aw.push_back({32'h0000_03FC, 3'b001});
    exp_w.push_back({32'hCAFE_F00D, 4'b0101});
    b_ret.push_back(2'b00);
    exp_b.push_back(2'b00);
    fork
      aw_send(32'h1000_00FF, 3'b001);
      w_send(32'hCAFE_F00D, 4'b0101);
    join
    wait_drain("wr_win1");

    // read miss -> local DECERR
    exp_r.push_back({32'h0, 2'b11});
    exp_err++;
    ar_send(32'h2000_0000, 3'b000);
    wait_drain("rd_miss");

    // W three cycles ahead of AW; downstream wready two cycles ahead of awready
    aw_lat = 2; w_lat = 0;
    exp_aw.push_back({32'h0000_0FFC, 3'b000});
    exp_w.push_back({32'h1122_3344, 4'b1111});
    b_ret.push_back(2'b10);
    exp_b.push_back(2'b10);
    fork
      w_send(32'h1122_3344, 4'b1111);
      begin
        repeat (3) begin @(posedge clk); #1; end
        aw_send(32'h8000_0FFC, 3'b000);
      end
    join
    wait_drain("wr_skew");
    aw_lat = 0;

    // write miss -> local DECERR, data dropped
    exp_b.push_back(2'b11);
    exp_err++;
    fork
      aw_send(32'h0000_0000, 3'b000);
      w_send(32'hFFFF_FFFF, 4'b1111);
    join
    wait_drain("wr_miss");

    // upstream back-pressure on R
    s_if.rready = 0;
    exp_ar.push_back({32'h0000_0004, 3'b000});
    rd_ret.push_back({32'hA5A5_5A5A, 2'b00});
    exp_r.push_back({32'hA5A5_5A5A, 2'b00});
    ar_send(32'h8000_0004, 3'b000);
    repeat (6) begin @(posedge clk); #1; end
    s_if.rready = 1;
    wait_drain("rd_stall");

    // reset while in R_DATA abandons the read
    s_if.rready = 0;
    exp_ar.push_back({32'h0000_0008, 3'b000});
    rd_ret.push_back({32'h0000_0BAD, 2'b00});
    ar_send(32'h8000_0008, 3'b000);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_if.rvalid) break;
    end
    check("rdata_phase_reached", s_if.rvalid, 1'b1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valids", {s_if.rvalid, s_if.bvalid, m_if.arvalid, m_if.awvalid, m_if.wvalid}, 5'b0);
    check("mid_rst_m_rready", m_if.rready, 1'b0);
    check("mid_rst_arready", s_if.arready, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    check("rerst_readies", {s_if.arready, s_if.awready, s_if.wready}, 3'b111);
    check("rerst_rvalid", s_if.rvalid, 1'b0);
    @(posedge clk); #1;
    s_if.rready = 1;
    wait_drain("rd_rst");

    // concurrent read (window 1) and write (window 0) in the same cycle
    exp_ar.push_back({32'h0000_0080, 3'b000});
    rd_ret.push_back({32'h0BAD_F00D, 2'b00});
    exp_r.push_back({32'h0BAD_F00D, 2'b00});
    exp_aw.push_back({32'h0000_0100, 3'b000});
    exp_w.push_back({32'h5555_AAAA, 4'b1111});
    b_ret.push_back(2'b00);
    exp_b.push_back(2'b00);
    fork
      ar_send(32'h1000_0020, 3'b000);
      aw_send(32'h8000_0100, 3'b000);
      w_send(32'h5555_AAAA, 4'b1111);
    join
    wait_drain("concurrent");

    repeat (3) begin @(posedge clk); #1; end
    check("err_hit_pulses", 64'(err_cnt), 64'(exp_err));
    check("rd_ret_consumed", 64'(rd_ret.size()), 64'd0);
    check("b_ret_consumed", 64'(b_ret.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
